// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single data-memory port between the MEM stage (p_) and a debug/loader requester (d_).
// Latency: writes complete in the issue cycle; reads return RD_LAT cycles after issue and block the port until then.
// Backpressure: p_stall holds the pipeline until its access is done; d_ waits for d_gnt, bounded by MAX_WAIT lost arbitrations.
module dm_port_arbiter #(
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  input  logic [3:0]  p_be,
  output logic        p_stall,
  output logic [31:0] p_rdata,
  output logic        p_rvalid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic [31:0] m_rdata
);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);
  localparam logic [3:0] WAIT_SAT = 4'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [2:0] lat_cnt, lat_cnt_nxt;
  logic       owner, owner_nxt;      // 0 = pipeline, 1 = debug
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       d_win, p_win, ret_cyc, p_done;

  // State register; asserting reset abandons any in-flight read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lat_cnt  <= 3'd0;
      owner    <= 1'b0;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_cnt_nxt;
      owner    <= owner_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Arbitration, issue muxing, read-return steering and next-state logic.
  // Everything is gated by reset so outputs read as idle while it is held low.
  always_comb begin
    state_nxt    = state;
    lat_cnt_nxt  = lat_cnt;
    owner_nxt    = owner;
    wait_cnt_nxt = wait_cnt;
    d_win        = 1'b0;
    p_win        = 1'b0;
    ret_cyc      = 1'b0;
    p_done       = 1'b0;
    m_en         = 1'b0;
    m_we         = 1'b0;
    m_addr       = 32'd0;
    m_wdata      = 32'd0;
    m_be         = 4'd0;
    d_gnt        = 1'b0;
    p_rdata      = 32'd0;
    p_rvalid     = 1'b0;
    d_rdata      = 32'd0;
    d_rvalid     = 1'b0;

    if (reset && state == IDLE) begin
      // Starved debug requester overrides the pipeline's fixed priority.
      if (d_req && wait_cnt == WAIT_SAT) d_win = 1'b1;
      else if (p_req)                    p_win = 1'b1;
      else if (d_req)                    d_win = 1'b1;

      if (p_win) begin
        m_en    = 1'b1;
        m_we    = p_we;
        m_addr  = p_addr;
        m_wdata = p_wdata;
        m_be    = p_be;
      end else if (d_win) begin
        m_en    = 1'b1;
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_be    = d_be;
        d_gnt   = 1'b1;
      end

      if (d_win) begin
        wait_cnt_nxt = 4'd0;
      end else if (d_req && wait_cnt != WAIT_SAT) begin
        wait_cnt_nxt = wait_cnt + 4'd1;
      end

      // Reads occupy the port until the data returns; writes finish now.
      if (m_en && !m_we) begin
        state_nxt   = RD_WAIT;
        lat_cnt_nxt = LAT_INIT;
        owner_nxt   = d_win;
      end
    end else if (reset && state == RD_WAIT) begin
      lat_cnt_nxt = lat_cnt - 3'd1;
      if (lat_cnt == 3'd1) begin
        ret_cyc   = 1'b1;
        state_nxt = IDLE;
      end
    end

    if (ret_cyc && !owner) begin
      p_rdata  = m_rdata;
      p_rvalid = 1'b1;
    end
    if (ret_cyc && owner) begin
      d_rdata  = m_rdata;
      d_rvalid = 1'b1;
    end

    p_done  = (p_win && p_we) || (ret_cyc && !owner);
    p_stall = p_req && !p_done;
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: scoreboard bench for dm_port_arbiter with a small behavioural memory.
// Latency: memory model returns read data RD_LAT cycles after the issue cycle.
// Backpressure: stimulus holds pipeline inputs while p_stall is high, as a real MEM stage would.
module tb_dm_port_arbiter;

  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_req, p_we, p_stall, p_rvalid;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic [3:0]  p_be;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {owner (1 = debug), expected read data}.
  logic [32:0] sb[$];
  logic [32:0] exp_e;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_pipe [RD_LAT];

  always #5 clk = ~clk;

  dm_port_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_be(p_be),
    .p_stall(p_stall), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  // Behavioural memory: byte-masked writes, fixed-latency read pipe.
  always @(posedge clk) begin
    logic [31:0] w;
    if (reset && m_en && m_we) begin
      w = mem_rd(m_addr);
      for (int b = 0; b < 4; b++) if (m_be[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
      mem[m_addr] = w;
    end
    rd_pipe[0] <= (m_en && !m_we) ? mem_rd(m_addr) : 32'hBAD0_BAD0;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign m_rdata = rd_pipe[RD_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0; p_be = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (m_en !== 0 || m_we !== 0 || m_addr !== 0 || m_wdata !== 0 || m_be !== 0 || d_gnt !== 0 ||
        p_rvalid !== 0 || d_rvalid !== 0 || p_rdata !== 0 || d_rdata !== 0 || p_stall !== 0) begin
      errors++;
      $display("FAIL reset_outputs: m_en=%0b m_addr=%h d_gnt=%0b p_stall=%0b rvalid=%0b/%0b, expected all 0",
               m_en, m_addr, d_gnt, p_stall, p_rvalid, d_rvalid);
    end
    p_req = 1; d_req = 1;
    #1;
    checks++;
    if (p_stall !== 1 || m_en !== 0 || d_gnt !== 0) begin
      errors++;
      $display("FAIL reset_preq: p_stall=%0b m_en=%0b d_gnt=%0b, expected 1 0 0", p_stall, m_en, d_gnt);
    end
    idle_inputs();
    tick();
    reset = 1;
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (m_en !== 0 || m_addr !== 0 || d_gnt !== 0 || p_stall !== 0 || dut.wait_cnt !== 4'd0) begin
        errors++;
        $display("FAIL idle_%0d: m_en=%0b m_addr=%h d_gnt=%0b p_stall=%0b wait_cnt=%0d, expected all 0",
                 i, m_en, m_addr, d_gnt, p_stall, dut.wait_cnt);
      end
      tick();
    end
  endtask

  task automatic test_p_read();
    bit seen;
    mem[32'h10] = 32'hDEADBEEF;
    p_req = 1; p_we = 0; p_addr = 32'h10; p_be = 4'hF;
    @(negedge clk);
    checks++;
    if (m_en !== 1 || m_we !== 0 || m_addr !== 32'h10 || p_stall !== 1) begin
      errors++;
      $display("FAIL p_read_issue: m_en=%0b m_we=%0b m_addr=%h p_stall=%0b, expected 1 0 00000010 1",
               m_en, m_we, m_addr, p_stall);
    end
    sb.push_back({1'b0, 32'hDEADBEEF});
    tick();
    @(negedge clk);
    checks++;
    if (m_en !== 0 || p_stall !== 1 || p_rvalid !== 0) begin
      errors++;
      $display("FAIL p_read_wait: m_en=%0b p_stall=%0b p_rvalid=%0b, expected 0 1 0", m_en, p_stall, p_rvalid);
    end
    tick();
    @(negedge clk);
    exp_e = sb.pop_front();
    checks++;
    if (p_rvalid !== 1 || p_rdata !== exp_e[31:0] || p_stall !== 0 || m_en !== 0 || d_rvalid !== 0) begin
      errors++;
      $display("FAIL p_read_return: p_rvalid=%0b p_rdata=%h p_stall=%0b m_en=%0b, expected 1 %h 0 0",
               p_rvalid, p_rdata, p_stall, m_en, exp_e[31:0]);
    end
    tick();
    p_addr = 32'h14;
    @(negedge clk);
    checks++;
    if (m_en !== 1 || m_addr !== 32'h14) begin
      errors++;
      $display("FAIL p_read_next_issue: m_en=%0b m_addr=%h, expected 1 00000014", m_en, m_addr);
    end
    sb.push_back({1'b0, 32'hFFFFFFEB});
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      @(negedge clk);
      if (p_rvalid === 1) begin
        seen = 1;
        exp_e = sb.pop_front();
        checks++;
        if (p_rdata !== exp_e[31:0]) begin
          errors++;
          $display("FAIL p_read_second: p_rdata=%h, expected %h", p_rdata, exp_e[31:0]);
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL p_read_second_timeout: p_rvalid never rose, expected within 8 cycles");
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_p_write();
    bit seen;
    p_req = 1; p_we = 1; p_addr = 32'h20; p_wdata = 32'h12345678; p_be = 4'b1111;
    @(negedge clk);
    checks++;
    if (m_en !== 1 || m_we !== 1 || m_addr !== 32'h20 || m_wdata !== 32'h12345678 || m_be !== 4'hF || p_stall !== 0) begin
      errors++;
      $display("FAIL p_write: m_en=%0b m_we=%0b m_addr=%h m_wdata=%h m_be=%h p_stall=%0b, expected 1 1 20 12345678 f 0",
               m_en, m_we, m_addr, m_wdata, m_be, p_stall);
    end
    tick();
    // Back-to-back partial write to the same word.
    p_wdata = 32'hAAAAAAAA; p_be = 4'b0011;
    @(negedge clk);
    checks++;
    if (m_en !== 1 || m_we !== 1 || m_be !== 4'b0011 || p_stall !== 0 || dut.state !== 1'b0) begin
      errors++;
      $display("FAIL p_write_b2b: m_en=%0b m_we=%0b m_be=%h p_stall=%0b state=%0b, expected 1 1 3 0 0",
               m_en, m_we, m_be, p_stall, dut.state);
    end
    tick();
    p_we = 0; p_be = 4'hF;
    sb.push_back({1'b0, 32'h1234AAAA});
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (p_rvalid === 1) begin
        seen = 1;
        exp_e = sb.pop_front();
        checks++;
        if (p_rdata !== exp_e[31:0] || d_rvalid !== 0) begin
          errors++;
          $display("FAIL p_write_readback: p_rdata=%h d_rvalid=%0b, expected %h 0", p_rdata, d_rvalid, exp_e[31:0]);
        end
      end
      tick();
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL p_write_readback_timeout: p_rvalid never rose, expected within 8 cycles");
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    for (int i = 0; i < MAX_WAIT; i++) begin
      p_req = 1; p_we = 1; p_addr = 32'h100 + 32'(4*i); p_wdata = 32'(i); p_be = 4'hF;
      d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D; d_be = 4'hF;
      @(negedge clk);
      checks++;
      if (d_gnt !== 0 || p_stall !== 0 || m_addr !== 32'h100 + 32'(4*i) || dut.wait_cnt !== 4'(i)) begin
        errors++;
        $display("FAIL starve_p_wins_%0d: d_gnt=%0b p_stall=%0b m_addr=%h wait_cnt=%0d, expected 0 0 %h %0d",
                 i, d_gnt, p_stall, m_addr, dut.wait_cnt, 32'h100 + 32'(4*i), i);
      end
      tick();
    end
    p_addr = 32'h110; p_wdata = 32'h4;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1 || m_addr !== 32'h40 || m_wdata !== 32'hCAFEF00D || m_we !== 1 || p_stall !== 1) begin
      errors++;
      $display("FAIL starve_d_wins: d_gnt=%0b m_addr=%h m_wdata=%h m_we=%0b p_stall=%0b, expected 1 40 cafef00d 1 1",
               d_gnt, m_addr, m_wdata, m_we, p_stall);
    end
    tick();
    d_req = 0;
    @(negedge clk);
    checks++;
    if (d_gnt !== 0 || m_addr !== 32'h110 || p_stall !== 0 || dut.wait_cnt !== 4'd0) begin
      errors++;
      $display("FAIL starve_after: d_gnt=%0b m_addr=%h p_stall=%0b wait_cnt=%0d, expected 0 110 0 0",
               d_gnt, m_addr, p_stall, dut.wait_cnt);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_d_read_blocks_p();
    bit seen;
    d_req = 1; d_we = 0; d_addr = 32'h40; d_be = 4'hF;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1 || m_en !== 1 || m_we !== 0 || p_stall !== 0) begin
      errors++;
      $display("FAIL d_read_issue: d_gnt=%0b m_en=%0b m_we=%0b p_stall=%0b, expected 1 1 0 0", d_gnt, m_en, m_we, p_stall);
    end
    sb.push_back({1'b1, 32'hCAFEF00D});
    tick();
    d_req = 0;
    p_req = 1; p_we = 0; p_addr = 32'h20; p_be = 4'hF;
    @(negedge clk);
    checks++;
    if (p_stall !== 1 || m_en !== 0 || d_rvalid !== 0 || d_gnt !== 0) begin
      errors++;
      $display("FAIL d_read_wait: p_stall=%0b m_en=%0b d_rvalid=%0b d_gnt=%0b, expected 1 0 0 0", p_stall, m_en, d_rvalid, d_gnt);
    end
    tick();
    @(negedge clk);
    exp_e = sb.pop_front();
    checks++;
    if (d_rvalid !== 1 || d_rdata !== exp_e[31:0] || p_rvalid !== 0 || p_rdata !== 0 || p_stall !== 1 || exp_e[32] !== 1'b1) begin
      errors++;
      $display("FAIL d_read_return: d_rvalid=%0b d_rdata=%h p_rvalid=%0b p_rdata=%h p_stall=%0b, expected 1 %h 0 0 1",
               d_rvalid, d_rdata, p_rvalid, p_rdata, p_stall, exp_e[31:0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (m_en !== 1 || m_addr !== 32'h20 || d_rvalid !== 0) begin
      errors++;
      $display("FAIL d_read_p_follow: m_en=%0b m_addr=%h d_rvalid=%0b, expected 1 20 0", m_en, m_addr, d_rvalid);
    end
    sb.push_back({1'b0, 32'h1234AAAA});
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      @(negedge clk);
      if (p_rvalid === 1) begin
        seen = 1;
        exp_e = sb.pop_front();
        checks++;
        if (p_rdata !== exp_e[31:0]) begin
          errors++;
          $display("FAIL d_read_p_data: p_rdata=%h, expected %h", p_rdata, exp_e[31:0]);
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL d_read_p_timeout: p_rvalid never rose, expected within 8 cycles");
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    p_req = 1; p_we = 0; p_addr = 32'h10; p_be = 4'hF;
    tick();
    reset = 0;
    #1;
    checks++;
    if (m_en !== 0 || p_stall !== 1 || p_rvalid !== 0 || d_rvalid !== 0 || d_gnt !== 0 || p_rdata !== 0) begin
      errors++;
      $display("FAIL reset_mid_read: m_en=%0b p_stall=%0b p_rvalid=%0b d_rvalid=%0b d_gnt=%0b, expected 0 1 0 0 0",
               m_en, p_stall, p_rvalid, d_rvalid, d_gnt);
    end
    p_req = 0;
    tick();
    reset = 1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (p_rvalid !== 0 || d_rvalid !== 0) seen = 1;
      tick();
    end
    checks++;
    if (seen || dut.state !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: stray_rvalid=%0b state=%0b, expected 0 0", seen, dut.state);
    end
    p_req = 1; p_addr = 32'h10;
    sb.push_back({1'b0, 32'hDEADBEEF});
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (p_rvalid === 1) begin
        seen = 1;
        exp_e = sb.pop_front();
        checks++;
        if (p_rdata !== exp_e[31:0] || p_stall !== 0) begin
          errors++;
          $display("FAIL reset_fresh_read: p_rdata=%h p_stall=%0b, expected %h 0", p_rdata, p_stall, exp_e[31:0]);
        end
      end
      tick();
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL reset_fresh_timeout: p_rvalid never rose, expected within 8 cycles");
    end
    idle_inputs();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_p_read();
    test_p_write();
    test_starvation();
    test_d_read_blocks_p();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
